weight_bram_loader: RTL and testbench

Write-side counterpart of the weight fetch path: accepts a valid/ready stream of quantized weights and biases and packs them into BRAM lines. Each line holds N weights in byte lanes plus one bias, in exactly the layout and bank/address map the parallel fetcher reads. The block sits between the host/config interface and the TEMP `memory_weights` banks, whose write ports it drives. It runs once per `start` to fill all sections, then signals `done`.

---
 rtl/weight_loader_pkg.sv | 14 +
 rtl/weight_line_packer.sv | 40 ++++
 rtl/weight_bram_loader.sv | 122 ++++++++++++
 tb/tb_weight_bram_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared lane width, loader FSM states and row/bank mapping helpers
package weight_loader_pkg;
    localparam int LANE_WIDTH = 8;

    typedef enum logic [2:0] {IDLE, WEIGHTS, BIAS, WRITE, DONE} state_t;

    function automatic int section_length(input int m, input int temp);
        return m / temp;
    endfunction

    function automatic int bank_of(input int r, input int sl);
        return r / sl;
    endfunction
endpackage

// File: rtl/weight_line_packer.sv
// weight_line_packer: assembles one BRAM line from lane-indexed weights and a trailing bias
module weight_line_packer
    import weight_loader_pkg::*;
#(
    parameter int BRAM_WIDTH     = 64,
    parameter int N              = 4,
    parameter int PRECISION      = 5,
    parameter int BIAS_PRECISION = 32,
    parameter int LW             = 2
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [LW-1:0]             lane_i,
    input  logic                      weight_we_i,
    input  logic                      bias_we_i,
    input  logic                      clear_i,
    input  logic [BIAS_PRECISION-1:0] data_i,
    output logic [BRAM_WIDTH-1:0]     line_o
);
    logic [BRAM_WIDTH-1:0] line_q, line_d;

    // Merge the accepted beat into its lane (or the bias field); a write cycle empties the buffer
    always_comb begin
        line_d = line_q;
        for (int j = 0; j < N; j++)
            if (weight_we_i && lane_i == LW'(j))
                line_d[j*LANE_WIDTH +: PRECISION] = data_i[PRECISION-1:0];
        if (bias_we_i)
            line_d[N*LANE_WIDTH +: BIAS_PRECISION] = data_i;
        if (clear_i)
            line_d = '0;
    end

    // Line buffer register
    always_ff @(posedge clk) begin
        line_q <= clr ? '0 : line_d;
    end

    assign line_o = line_q;
endmodule

// File: rtl/weight_bram_loader.sv
// weight_bram_loader: packs a weight/bias stream into banked BRAM lines; LOADER_CHECKSUM_EN adds a running checksum output
module weight_bram_loader
    import weight_loader_pkg::*;
#(
    parameter int BRAM_WIDTH     = 64,
    parameter int TEMP           = 2,
    parameter int M              = 5,
    parameter int N              = 4,
    parameter int BIAS_PRECISION = 32,
    parameter int PRECISION      = 5
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [BIAS_PRECISION-1:0] s_data,
    output logic [TEMP-1:0]           wr_en,
    output logic [(M>1 ? $clog2(M) : 1)-1:0] wr_addr,
    output logic [BRAM_WIDTH-1:0]     wr_data,
    output logic                      busy,
    output logic                      done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]               checksum
`endif
);
    localparam int SL   = section_length(M, TEMP);
    localparam int ROWS = TEMP * SL;
    localparam int AW   = M > 1 ? $clog2(M) : 1;
    localparam int LW   = N > 1 ? $clog2(N) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          xfer;

    assign xfer    = s_valid && s_ready;
    assign wr_addr = row_q;

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            row_q   <= '0;
            lane_q  <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            lane_q  <= lane_d;
            s_ready <= state_d == WEIGHTS || state_d == BIAS;
            busy    <= state_d != IDLE;
            done    <= state_d == DONE;
            wr_en   <= state_d == WRITE ? TEMP'(1) << bank_of(int'(row_d), SL) : '0;
        end
    end

    // Next-state: N weight beats, one bias beat, one write cycle per row
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE:
                if (start) begin
                    state_d = WEIGHTS;
                    row_d   = '0;
                    lane_d  = '0;
                end
            WEIGHTS:
                if (xfer) begin
                    lane_d  = lane_q + 1'b1;
                    state_d = lane_q == LW'(N-1) ? BIAS : WEIGHTS;
                end
            BIAS:
                state_d = xfer ? WRITE : BIAS;
            WRITE:
                if (row_q == AW'(ROWS-1)) begin
                    state_d = DONE;
                end else begin
                    state_d = WEIGHTS;
                    row_d   = row_q + 1'b1;
                    lane_d  = '0;
                end
            DONE:
                state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    weight_line_packer #(
        .BRAM_WIDTH    (BRAM_WIDTH),
        .N             (N),
        .PRECISION     (PRECISION),
        .BIAS_PRECISION(BIAS_PRECISION),
        .LW            (LW)
    ) u_packer (
        .clk        (clk),
        .clr        (clr),
        .lane_i     (lane_q),
        .weight_we_i(xfer && state_q == WEIGHTS),
        .bias_we_i  (xfer && state_q == BIAS),
        .clear_i    (state_q == WRITE),
        .data_i     (s_data),
        .line_o     (wr_data)
    );

`ifdef LOADER_CHECKSUM_EN
    // Wrapping sum of every accepted beat since the last accepted start
    always_ff @(posedge clk) begin
        if (clr || (state_q == IDLE && start))
            checksum <= '0;
        else if (xfer)
            checksum <= checksum + 32'(s_data);
    end
`endif
endmodule

// File: tb/tb_weight_bram_loader.sv
// tb_weight_bram_loader: directed loads checked by a write-port scoreboard
module tb_weight_bram_loader;
    logic        clk = 0, clr = 1, start = 0, s_valid = 0;
    logic [31:0] s_data = 0;
    logic        s_ready, busy, done;
    logic [1:0]  wr_en;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    weight_bram_loader dut (
        .clk(clk), .clr(clr), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [2:0]  addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0, passed = 0, ec = 0, base = 0;
    bit          mon_on = 0;
    logic [31:0] beats[4][5];
    logic [63:0] lines[4];

    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every write-port strobe is matched against the next expected line
    always @(negedge clk) begin
        exp_t e;
        if (mon_on && wr_en !== 2'b00) begin
            chk("ready_during_write", s_ready, 0);
            if (q.size() == 0) begin
                chk("unexpected_write", wr_en, 0);
            end else begin
                e = q.pop_front();
                chk("wr_en", wr_en, e.en);
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                if (e.cyc >= 0) chk("write_cycle", ec - base, e.cyc);
            end
        end
    end

    task automatic put(input logic [31:0] d, input bit gaps);
        int n = 0;
        bit acc = 0;
        if (gaps)
            while ($urandom_range(1) == 0) begin
                s_valid = 0;
                @(negedge clk);
            end
        s_valid = 1;
        s_data  = d;
        do begin
            acc = s_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("beat_timeout", acc, 1);
    endtask

    task automatic do_start();
        start = 1;
        base  = ec;
        @(negedge clk);
        start = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic load(input bit gaps, input bit timed, input bit poke);
        int n = 0;
        do_start();
        for (int r = 0; r < 4; r++) begin
            q.push_back('{en: 2'b01 << (r / 2), addr: 3'(r), data: lines[r], cyc: timed ? 6 * (r + 1) : -1});
            for (int k = 0; k < 5; k++) begin
                put(beats[r][k], gaps);
                if (poke && r == 0 && k == 1) start = 1;
                if (poke && r == 0 && k == 2) start = 0;
`ifdef LOADER_CHECKSUM_EN
                if (r == 0 && k == 4) chk("checksum_row0", checksum, 32'hDEADBEF9);
`endif
            end
        end
        s_valid = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        if (timed) chk("done_cycle", ec - base, 25);
        chk("busy_in_done", busy, 1);
        if (poke) start = 1;
        @(negedge clk);
        start = 0;
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", s_ready, 0);
            chk("idle_busy", busy, 0);
        end
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beats = '{'{32'h01, 32'h02, 32'h03, 32'h04, 32'hDEADBEEF},
                  '{32'hFF, 32'h20, 32'h1F, 32'hA5, 32'h12345678},
                  '{32'h10, 32'h0F, 32'hE1, 32'h33, 32'h00000000},
                  '{32'h07, 32'h08, 32'h09, 32'h1E, 32'hFFFFFFFF}};
        lines = '{64'hDEADBEEF_04030201, 64'h12345678_051F001F,
                  64'h00000000_13010F10, 64'hFFFFFFFF_1E090807};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        clr = 0;
        mon_on = 1;
        @(negedge clk);

        load(0, 1, 1);
        load(1, 0, 0);

        do_start();
        q.push_back('{en: 2'b01, addr: 3'd0, data: lines[0], cyc: -1});
        for (int k = 0; k < 5; k++) put(beats[0][k], 0);
        put(beats[1][0], 0);
        put(beats[1][1], 0);
        s_valid = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        check_reset_outputs("after_clr");
        repeat (4) @(negedge clk);
        chk("clr_queue_drained", q.size(), 0);

        load(0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
